// File: rtl/conv_pkg.sv
// Shared types, constants and FP16 arithmetic helpers for the KxK convolution datapath.
package conv_pkg;

  typedef logic [15:0] fp16_t;

  localparam fp16_t FP16_ZERO = 16'h0000;
  localparam fp16_t FP16_ONE  = 16'h3C00;

  typedef enum logic [1:0] {K_EMPTY, K_LOADING, K_READY} kstate_t;

  function automatic int tree_levels(input int n);
    int l;
    l = 0;
    for (int i = 0; i < 31; i++) if ((32'sd1 <<< i) < n) l = i + 1;
    return l;
  endfunction

  // Live element count at a given tree level
  function automatic int level_width(input int n, input int l);
    return (n + (32'sd1 <<< l) - 1) >>> l;
  endfunction

  // mulfp16: subnormals flush to zero, truncating, overflow saturates to infinity
  function automatic fp16_t fp16_mul(input fp16_t a, input fp16_t b);
    logic        s;
    logic [21:0] p;
    logic [9:0]  m;
    int          e;
    s = a[15] ^ b[15];
    if (a[14:10] == 5'd0 || b[14:10] == 5'd0) return {s, 15'd0};
    p = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (p[21]) begin
      m = p[20:11];
      e = e + 1;
    end else begin
      m = p[19:10];
    end
    if (e <= 0)  return {s, 15'd0};
    if (e >= 31) return {s, 5'h1F, 10'd0};
    return {s, 5'(e), m};
  endfunction

  // addfp16: same special-case policy as fp16_mul, three guard bits then truncate
  function automatic fp16_t fp16_add(input fp16_t a, input fp16_t b);
    fp16_t       x, y;
    logic [14:0] mx, my;
    logic [15:0] s;
    int          e, d;
    if (a[14:0] >= b[14:0]) begin
      x = a; y = b;
    end else begin
      x = b; y = a;
    end
    if (y[14:10] == 5'd0) return (x[14:10] == 5'd0) ? FP16_ZERO : x;
    if (x[14:10] == 5'h1F) return x;
    mx = {2'b01, x[9:0], 3'd0};
    my = {2'b01, y[9:0], 3'd0};
    d  = int'(x[14:10]) - int'(y[14:10]);
    my = (d > 14) ? 15'd0 : (my >> d);
    e  = int'(x[14:10]);
    if (x[15] == y[15]) s = 16'(mx) + 16'(my);
    else                s = 16'(mx) - 16'(my);
    if (s == 16'd0) return FP16_ZERO;
    if (s[14]) begin
      s = s >> 1;
      e = e + 1;
    end
    for (int i = 0; i < 13; i++) begin
      if (!s[13]) begin
        s = s << 1;
        e = e - 1;
      end
    end
    if (e <= 0)  return FP16_ZERO;
    if (e >= 31) return {x[15], 5'h1F, 10'd0};
    return {x[15], 5'(e), s[12:3]};
  endfunction

endpackage

// File: rtl/conv_kxk_pipe_if.sv
// Row-stream in / result-stream out bus of the KxK convolution engine.
interface conv_kxk_pipe_if #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned KERNEL_SIZE = 3
);
  logic [DATA_WIDTH-1:0] data_in [KERNEL_SIZE];
  logic                  valid_in;
  logic                  kernel_load;
  logic                  window_clear;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  out_ready;
  logic                  kernel_ready;

  modport master (
    output data_in, valid_in, kernel_load, window_clear, out_ready,
    input  in_ready, data_out, valid_out, kernel_ready
  );

  modport slave (
    input  data_in, valid_in, kernel_load, window_clear, out_ready,
    output in_ready, data_out, valid_out, kernel_ready
  );
endinterface

// File: rtl/fp16_add_tree_pipe.sv
// Registered pairwise FP16 reduction tree, one level per stage, with valid shift and stall enable.
module fp16_add_tree_pipe
  import conv_pkg::*;
#(
  parameter int unsigned N      = 9,
  parameter int unsigned LEVELS = 4,
  parameter bit          RELU   = 1'b0
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  en,
  input  logic  in_valid,
  input  fp16_t in_data [N],
  output fp16_t out_data,
  output logic  out_valid
);

  fp16_t             q [LEVELS+1][N];
  fp16_t             d [LEVELS+1][N];
  fp16_t             a0, a1;
  logic [LEVELS-1:0] vq;

  // Level l pairs (2j, 2j+1) of level l-1; an unpaired tail element is carried through
  always_comb begin
    a0 = FP16_ZERO;
    a1 = FP16_ZERO;
    for (int l = 0; l <= LEVELS; l++)
      for (int j = 0; j < N; j++) d[l][j] = FP16_ZERO;
    for (int l = 1; l <= LEVELS; l++) begin
      for (int j = 0; j < N; j++) begin
        if (j < level_width(N, l)) begin
          a0 = (l == 1) ? in_data[(2*j) % N]   : q[l-1][(2*j) % N];
          a1 = (l == 1) ? in_data[(2*j+1) % N] : q[l-1][(2*j+1) % N];
          d[l][j] = (2*j + 1 < level_width(N, l - 1)) ? fp16_add(a0, a1) : a0;
          if (RELU && l == LEVELS && d[l][j][15]) d[l][j] = FP16_ZERO;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int l = 0; l <= LEVELS; l++)
        for (int j = 0; j < N; j++) q[l][j] <= FP16_ZERO;
      vq <= '0;
    end else if (en) begin
      for (int l = 1; l <= LEVELS; l++) q[l] <= d[l];
      vq <= {vq[LEVELS-2:0], in_valid};
    end
  end

  assign out_data  = q[LEVELS][0];
  assign out_valid = vq[LEVELS-1];

endmodule

// File: rtl/conv_kxk_pipe.sv
// Pipelined KxK FP16 convolution: kernel and image rows share one row stream.
// Build option: define CONV_RELU_EN to clamp negative results (including -0) to +0.
module conv_kxk_pipe
  import conv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned KERNEL_SIZE = 3
) (
  input logic            clk,
  input logic            rst,
  conv_kxk_pipe_if.slave bus
);

  localparam int unsigned K      = KERNEL_SIZE;
  localparam int unsigned NK     = K * K;
  localparam int unsigned LEVELS = tree_levels(NK);
  localparam int unsigned CNT_W  = $clog2(K + 1);
`ifdef CONV_RELU_EN
  localparam bit RELU_EN = 1'b1;
`else
  localparam bit RELU_EN = 1'b0;
`endif

  kstate_t          state_q, state_d;
  logic [CNT_W-1:0] krow_q, krow_d, fill_q, fill_d;
  logic             kready_q, kready_d, launch_q, launch_d, prod_v_q;
  logic             adv, accept, kbeat, ibeat;
  fp16_t            win_q  [K][K];
  fp16_t            ker_q  [K][K];
  fp16_t            prod_q [NK];

  assign adv          = !(bus.valid_out && !bus.out_ready);
  assign accept       = bus.valid_in && adv;
  assign kbeat        = accept && bus.kernel_load;
  assign ibeat        = accept && !bus.kernel_load;
  assign bus.in_ready = adv;
  assign bus.kernel_ready = kready_q;

  // Kernel-load FSM: counts K rows, any kernel beat in K_READY starts a reload
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= K_EMPTY;
      krow_q   <= '0;
      kready_q <= 1'b0;
    end else if (adv) begin
      state_q  <= state_d;
      krow_q   <= krow_d;
      kready_q <= kready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    krow_d  = krow_q;
    if (kbeat) begin
      case (state_q)
        K_LOADING: begin
          krow_d = krow_q + CNT_W'(1);
          if (krow_q == CNT_W'(K - 1)) state_d = K_READY;
        end
        default: begin
          state_d = K_LOADING;
          krow_d  = CNT_W'(1);
        end
      endcase
    end
    kready_d = (state_d == K_READY);
  end

  // Window fill tracking; a launch needs a resident kernel and a full window after the shift
  always_comb begin
    fill_d   = fill_q;
    launch_d = 1'b0;
    if (ibeat) begin
      if (bus.window_clear)         fill_d = CNT_W'(1);
      else if (fill_q != CNT_W'(K)) fill_d = fill_q + CNT_W'(1);
      launch_d = kready_q && (fill_d == CNT_W'(K));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q   <= '0;
      launch_q <= 1'b0;
      prod_v_q <= 1'b0;
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++) begin
          win_q[i][j] <= FP16_ZERO;
          ker_q[i][j] <= FP16_ZERO;
        end
      for (int n = 0; n < NK; n++) prod_q[n] <= FP16_ZERO;
    end else if (adv) begin
      fill_q   <= fill_d;
      launch_q <= launch_d;
      prod_v_q <= launch_q;
      if (ibeat) begin
        for (int i = 0; i < K - 1; i++) win_q[i] <= win_q[i+1];
        for (int j = 0; j < K; j++) win_q[K-1][j] <= fp16_t'(bus.data_in[j]);
      end
      if (kbeat) begin
        for (int i = 0; i < K - 1; i++) ker_q[i] <= ker_q[i+1];
        for (int j = 0; j < K; j++) ker_q[K-1][j] <= fp16_t'(bus.data_in[j]);
      end
      // Products capture the kernel now, so a later reload cannot disturb this result
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++) prod_q[i*K + j] <= fp16_mul(win_q[i][j], ker_q[i][j]);
    end
  end

  fp16_add_tree_pipe #(
    .N      (NK),
    .LEVELS (LEVELS),
    .RELU   (RELU_EN)
  ) u_tree (
    .clk       (clk),
    .rst       (rst),
    .en        (adv),
    .in_valid  (prod_v_q),
    .in_data   (prod_q),
    .out_data  (bus.data_out),
    .out_valid (bus.valid_out)
  );

endmodule

// File: tb/tb_conv_kxk_pipe.sv
// Directed vector bench for conv_kxk_pipe (K=3): per-cycle table plus an async-reset sequence.
module tb_conv_kxk_pipe;
  import conv_pkg::*;

  localparam fp16_t TWO   = 16'h4000;
  localparam fp16_t THREE = 16'h4200;
  localparam fp16_t MONE  = 16'hBC00;
`ifdef CONV_RELU_EN
  localparam fp16_t NEG6  = 16'h0000;
  localparam fp16_t NEG18 = 16'h0000;
`else
  localparam fp16_t NEG6  = 16'hC600;
  localparam fp16_t NEG18 = 16'hCC80;
`endif

  typedef struct {
    logic  vin;
    logic  kl;
    logic  wc;
    logic  ordy;
    fp16_t row;
    logic  ev;
    fp16_t ed;
    logic  ekr;
    logic  eir;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  vec_t tbl[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  conv_kxk_pipe_if #(.DATA_WIDTH(16), .KERNEL_SIZE(3)) bus ();

  conv_kxk_pipe #(.DATA_WIDTH(16), .KERNEL_SIZE(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic add(input logic vin, kl, wc, ordy, input fp16_t row,
                     input logic ev, input fp16_t ed, input logic ekr, eir);
    vec_t v;
    v = '{vin, kl, wc, ordy, row, ev, ed, ekr, eir};
    tbl.push_back(v);
  endtask

  task automatic img(input fp16_t row, input logic wc, input logic ev, input fp16_t ed, input logic kr);
    add(1'b1, 1'b0, wc, 1'b1, row, ev, ed, kr, 1'b1);
  endtask

  task automatic ker(input fp16_t row, input logic wc, input logic kr);
    add(1'b1, 1'b1, wc, 1'b1, row, 1'b0, FP16_ZERO, kr, 1'b1);
  endtask

  task automatic idle(input logic ev, input fp16_t ed, input logic kr);
    add(1'b0, 1'b0, 1'b0, 1'b1, FP16_ZERO, ev, ed, kr, 1'b1);
  endtask

  task automatic drive(input logic vin, kl, wc, ordy, input fp16_t row);
    bus.valid_in     = vin;
    bus.kernel_load  = kl;
    bus.window_clear = wc;
    bus.out_ready    = ordy;
    for (int j = 0; j < 3; j++) bus.data_in[j] = row;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic ok, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (!ok) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  initial begin
    logic ok;
    drive(1'b0, 1'b0, 1'b0, 1'b1, FP16_ZERO);
    #22 rst = 1'b0;

    // Reset state, then image rows before any kernel
    idle(0, 0, 0);
    for (int i = 0; i < 3; i++) img(FP16_ONE, 0, 0, 0, 0);
    ker(FP16_ONE, 0, 0); ker(FP16_ONE, 0, 0); ker(FP16_ONE, 0, 1);
    // All-ones: restart fill, 3 rows -> 9.0 five cycles later, 4th row -> second result
    img(FP16_ONE, 1, 0, 0, 1);
    for (int i = 0; i < 3; i++) img(FP16_ONE, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) idle(0, 0, 1);
    idle(1, 16'h4880, 1); idle(1, 16'h4880, 1); idle(0, 0, 1);
    // Backpressure: 12, 15, 18 queued; a beat offered while stalled must be dropped
    for (int i = 0; i < 3; i++) img(TWO, 0, 0, 0, 1);
    idle(0, 0, 1); idle(0, 0, 1);
    add(0, 0, 0, 0, FP16_ZERO, 1, 16'h4A00, 1, 0);
    add(1, 0, 0, 0, FP16_ONE,  1, 16'h4A00, 1, 0);
    add(0, 0, 0, 0, FP16_ZERO, 1, 16'h4A00, 1, 0);
    idle(1, 16'h4B80, 1); idle(1, 16'h4C80, 1); idle(0, 0, 1);
    img(FP16_ONE, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) idle(0, 0, 1);
    idle(1, 16'h4B80, 1);
    // window_clear: only the three post-clear rows of 3.0 -> 27.0
    img(THREE, 1, 0, 0, 1); img(THREE, 0, 0, 0, 1); img(THREE, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) idle(0, 0, 1);
    idle(1, 16'h4EC0, 1); idle(0, 0, 1);
    // Kernel reload to 2.0 with two results in flight; clear on a kernel beat is ignored
    img(FP16_ONE, 0, 0, 0, 1); img(FP16_ONE, 0, 0, 0, 1);
    ker(TWO, 0, 0); ker(TWO, 1, 0); ker(TWO, 0, 1);
    img(FP16_ONE, 0, 1, 16'h4D40, 1);
    idle(1, 16'h4B80, 1);
    for (int i = 0; i < 3; i++) idle(0, 0, 1);
    idle(1, 16'h4C80, 1);
    // Negative results: 6, -6, -18
    for (int i = 0; i < 3; i++) img(MONE, 0, 0, 0, 1);
    idle(0, 0, 1); idle(0, 0, 1);
    idle(1, 16'h4600, 1); idle(1, NEG6, 1); idle(1, NEG18, 1); idle(0, 0, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].vin, tbl[i].kl, tbl[i].wc, tbl[i].ordy, tbl[i].row);
      step();
      ok = (bus.valid_out === tbl[i].ev) && (!tbl[i].ev || bus.data_out === tbl[i].ed) &&
           (bus.kernel_ready === tbl[i].ekr) && (bus.in_ready === tbl[i].eir);
      n_vec++;
      if (!ok) begin
        n_miss++;
        $display("FAIL vec%0d: valid=%b data=%h kready=%b in_ready=%b, expected valid=%b data=%h kready=%b in_ready=%b",
                 i, bus.valid_out, bus.data_out, bus.kernel_ready, bus.in_ready,
                 tbl[i].ev, tbl[i].ed, tbl[i].ekr, tbl[i].eir);
      end
      if (i == 0) check("reset_data_out", bus.data_out === 16'h0000, 32'(bus.data_out), 32'h0);
    end

    // Async reset while three results are in flight, first one on the output
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 1, MONE);
      step();
    end
    drive(0, 0, 0, 1, FP16_ZERO);
    for (int i = 0; i < 3; i++) step();
    check("pre_reset_result", bus.valid_out === 1'b1 && bus.data_out === NEG18,
          {15'd0, bus.valid_out, bus.data_out}, {16'd1, NEG18});
    #2 rst = 1'b1;
    #1;
    check("async_reset_out", bus.valid_out === 1'b0 && bus.data_out === 16'h0000 && bus.kernel_ready === 1'b0,
          {14'd0, bus.kernel_ready, bus.valid_out, bus.data_out}, 32'h0);
    #2 rst = 1'b0;
    ok = 1'b1;
    drive(1, 0, 0, 1, FP16_ONE);
    for (int i = 0; i < 10; i++) begin
      step();
      if (i == 0) drive(0, 0, 0, 1, FP16_ZERO);
      if (bus.valid_out !== 1'b0 || bus.in_ready !== 1'b1 || bus.kernel_ready !== 1'b0) ok = 1'b0;
    end
    check("post_reset_quiet", ok, {29'd0, bus.kernel_ready, bus.in_ready, bus.valid_out}, 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
